// File: rtl/hub_pkg.sv
// Shared definitions for the hub link: field widths, frame header layout,
// transmitter state encoding and the running XOR checksum.
package hub_pkg;

    localparam int unsigned NODE_W    = 4;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BUF_DEPTH = 16;

    // Upper nibble of the LEN byte is reserved and sent as zero.
    localparam logic [3:0] LEN_HI = 4'h0;

    // Header byte: source in the upper nibble, destination in the lower.
    typedef struct packed {
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dst;
    } hub_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_HDR      = 3'd2,
        ST_LEN      = 3'd3,
        ST_DATA     = 3'd4,
        ST_CSUM     = 3'd5,
        ST_WAIT_ACK = 3'd6,
        ST_GAP      = 3'd7
    } hub_tx_state_e;

    function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/hub_tx_buf.sv
// Payload buffer: 16x8 register file, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   i_we/i_waddr/i_wdata : write port
//   i_raddr/o_rdata      : combinational read port
module hub_tx_buf
    import hub_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [LEN_W-1:0]  i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [LEN_W-1:0]  i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hub_node_tx.sv
// Node-side frame transmitter. Buffers one payload, requests the hub, sends
// HDR, LEN, payload and XOR checksum under grant, then waits for ACK/NAK.
// NAK, ACK timeout or grant loss retries the frame up to MAX_RETRY times.
//   load_en/load_addr/load_data : payload buffer write (idle only)
//   send/send_dst/send_len      : start a frame (idle only)
//   hub_req/hub_gnt             : bus request / grant
//   tx_valid/tx_data/tx_last/tx_ready : byte stream toward the hub
//   hub_ack/hub_nak             : frame response from the hub
//   busy/done/fail              : transfer status
module hub_node_tx
    import hub_pkg::*;
#(
    parameter logic [NODE_W-1:0] NODE_ID   = 4'd1,
    parameter int unsigned       MAX_RETRY = 3,
    parameter int unsigned       TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [LEN_W-1:0]  load_addr,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              send,
    input  logic [NODE_W-1:0] send_dst,
    input  logic [LEN_W-1:0]  send_len,
    output logic              hub_req,
    input  logic              hub_gnt,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_last,
    input  logic              tx_ready,
    input  logic              hub_ack,
    input  logic              hub_nak,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TMO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    hub_tx_state_e      r_state, w_state_nxt;
    logic [NODE_W-1:0]  r_dst, w_dst_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [LEN_W-1:0]   r_idx, w_idx_nxt;
    logic [BYTE_W-1:0]  r_csum, w_csum_nxt;
    logic [RETRY_W-1:0] r_retry, w_retry_nxt;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic [BYTE_W-1:0]  r_tx_data, w_tx_data_nxt;
    logic               r_hub_req, r_tx_valid, r_tx_last, r_busy, r_done, r_fail;
    logic               w_done_nxt, w_fail_nxt, w_attempt_bad;
    logic               w_hs, w_tx_active_nxt;
    logic [LEN_W-1:0]   w_rd_addr;
    logic [BYTE_W-1:0]  w_rd_data;
    hub_hdr_t           w_hdr;

    assign w_hdr = '{src: NODE_ID, dst: r_dst};
    assign w_hs  = r_tx_valid & tx_ready;

    // Read address looks one byte ahead so the next byte is ready on handshake.
    assign w_rd_addr = (r_state == ST_LEN) ? '0 : r_idx + LEN_W'(1);

    hub_tx_buf u_buf (
        .clk     (clk),
        .i_we    (load_en && (r_state == ST_IDLE)),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Next-state, datapath and retry decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_dst_nxt     = r_dst;
        w_len_nxt     = r_len;
        w_idx_nxt     = r_idx;
        w_csum_nxt    = r_csum;
        w_retry_nxt   = r_retry;
        w_tmo_nxt     = r_tmo;
        w_tx_data_nxt = r_tx_data;
        w_done_nxt    = 1'b0;
        w_fail_nxt    = 1'b0;
        w_attempt_bad = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (send) begin
                    w_dst_nxt   = send_dst;
                    w_len_nxt   = send_len;
                    w_retry_nxt = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (hub_gnt) begin
                    w_tx_data_nxt = w_hdr;
                    w_csum_nxt    = w_hdr;
                    w_state_nxt   = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!hub_gnt) begin
                    w_attempt_bad = 1'b1;
                end else if (w_hs) begin
                    w_tx_data_nxt = {LEN_HI, r_len};
                    w_csum_nxt    = csum_step(r_csum, {LEN_HI, r_len});
                    w_state_nxt   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (!hub_gnt) begin
                    w_attempt_bad = 1'b1;
                end else if (w_hs) begin
                    if (r_len == '0) begin
                        w_tx_data_nxt = r_csum;
                        w_state_nxt   = ST_CSUM;
                    end else begin
                        w_idx_nxt     = '0;
                        w_tx_data_nxt = w_rd_data;
                        w_csum_nxt    = csum_step(r_csum, w_rd_data);
                        w_state_nxt   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!hub_gnt) begin
                    w_attempt_bad = 1'b1;
                end else if (w_hs) begin
                    if (r_idx == r_len - LEN_W'(1)) begin
                        w_tx_data_nxt = r_csum;
                        w_state_nxt   = ST_CSUM;
                    end else begin
                        w_idx_nxt     = r_idx + LEN_W'(1);
                        w_tx_data_nxt = w_rd_data;
                        w_csum_nxt    = csum_step(r_csum, w_rd_data);
                    end
                end
            end
            ST_CSUM: begin
                if (!hub_gnt) begin
                    w_attempt_bad = 1'b1;
                end else if (w_hs) begin
                    w_tx_data_nxt = '0;
                    w_tmo_nxt     = '0;
                    w_state_nxt   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // NAK wins over a simultaneous ACK.
                if (hub_nak) begin
                    w_attempt_bad = 1'b1;
                end else if (hub_ack) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_attempt_bad = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_REQ;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_attempt_bad) begin
            w_tx_data_nxt = '0;
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
                w_retry_nxt = r_retry + RETRY_W'(1);
                w_state_nxt = ST_GAP;
            end else begin
                w_fail_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign w_tx_active_nxt = (w_state_nxt == ST_HDR) || (w_state_nxt == ST_LEN) ||
                             (w_state_nxt == ST_DATA) || (w_state_nxt == ST_CSUM);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_dst      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_retry    <= '0;
            r_tmo      <= '0;
            r_tx_data  <= '0;
            r_hub_req  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dst      <= w_dst_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_csum     <= w_csum_nxt;
            r_retry    <= w_retry_nxt;
            r_tmo      <= w_tmo_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_hub_req  <= w_tx_active_nxt || (w_state_nxt == ST_REQ);
            r_tx_valid <= w_tx_active_nxt;
            r_tx_last  <= (w_state_nxt == ST_CSUM);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_fail     <= w_fail_nxt;
        end
    end

    assign hub_req  = r_hub_req;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign tx_last  = r_tx_last;
    assign busy     = r_busy;
    assign done     = r_done;
    assign fail     = r_fail;

endmodule

// File: tb/tb_hub_node_tx.sv
// Bench for hub_node_tx: a responder drives grant/ready/ack/nak per scenario,
// pushing the expected frame bytes and outcomes; a monitor pops and compares.
module tb_hub_node_tx;

    localparam logic [3:0]  NODE_ID   = 4'd3;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TIMEOUT   = 64;

    localparam int A_ACK  = 0;
    localparam int A_NAK  = 1;
    localparam int A_BOTH = 2;
    localparam int A_TMO  = 3;
    localparam int A_DROP = 4;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       send;
    logic [3:0] send_dst;
    logic [3:0] send_len;
    logic       hub_req;
    logic       hub_gnt;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       hub_ack;
    logic       hub_nak;
    logic       busy;
    logic       done;
    logic       fail;

    hub_node_tx #(
        .NODE_ID   (NODE_ID),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .send      (send),
        .send_dst  (send_dst),
        .send_len  (send_len),
        .hub_req   (hub_req),
        .hub_gnt   (hub_gnt),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .hub_ack   (hub_ack),
        .hub_nak   (hub_nak),
        .busy      (busy),
        .done      (done),
        .fail      (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_byte_q[$];   // {last, data}
    logic [1:0] exp_out_q[$];    // {done, fail}
    int         req_rises = 0;

    // Transaction description
    logic [3:0] t_dst;
    logic [3:0] t_len;
    logic [7:0] t_pay[16];
    int         t_act[4];
    int         t_k[4];
    int         t_dly[4];
    int         t_rsp;
    int         t_rdy_mode;      // 0 always ready, 1 toggle, 2 random
    bit         t_noise;

    // Reference frame
    logic [7:0] m_fr[19];
    int         m_flen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    logic       m_prev_stall = 1'b0;
    logic [7:0] m_prev_data  = 8'h00;
    logic       m_prev_req   = 1'b0;
    always @(negedge clk) begin
        logic [8:0] eb;
        logic [1:0] eo;
        if (reset) begin
            if (tx_valid && tx_ready) begin
                if (exp_byte_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_byte_unexpected: got 0x%0h expected none at %0t", tx_data, $time);
                end else begin
                    eb = exp_byte_q.pop_front();
                    check("tx_byte", {23'b0, tx_last, tx_data}, {23'b0, eb});
                end
            end
            if (m_prev_stall) begin
                check("stall_valid", {31'b0, tx_valid}, 32'd1);
                check("stall_data", {24'b0, tx_data}, {24'b0, m_prev_data});
            end
            if (done || fail) begin
                if (exp_out_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL outcome_unexpected: got done=%0b fail=%0b expected no pulse at %0t",
                             done, fail, $time);
                end else begin
                    eo = exp_out_q.pop_front();
                    check("outcome", {30'b0, done, fail}, {30'b0, eo});
                end
                check("busy_at_outcome", {31'b0, busy}, 32'd0);
            end
            if (hub_req && !m_prev_req) req_rises++;
        end
        m_prev_stall = reset && tx_valid && !tx_ready && hub_gnt;
        m_prev_data  = tx_data;
        m_prev_req   = hub_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_frame();
        logic [7:0] c;
        m_fr[0] = {NODE_ID, t_dst};
        m_fr[1] = {4'h0, t_len};
        for (int i = 0; i < int'(t_len); i++) m_fr[2 + i] = t_pay[i];
        c = 8'h00;
        for (int i = 0; i < int'(t_len) + 2; i++) c = c ^ m_fr[i];
        m_fr[int'(t_len) + 2] = c;
        m_flen = int'(t_len) + 3;
    endfunction

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) exp_byte_q.push_back({(i == m_flen - 1), m_fr[i]});
    endtask

    task automatic load_buf();
        for (int i = 0; i < int'(t_len); i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_data = t_pay[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic wait_req();
        int c;
        c = 0;
        while (!hub_req && c < 200) begin
            tick();
            c++;
        end
        check("req_seen", {31'b0, hub_req}, 32'd1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 300) begin
            tick();
            c++;
        end
        check("busy_end", {31'b0, busy}, 32'd0);
    endtask

    task automatic start_send();
        send     = 1'b1;
        send_dst = t_dst;
        send_len = t_len;
        tick();
        send     = 1'b0;
        send_dst = 4'($urandom);
        send_len = 4'($urandom);
    endtask

    task automatic set_ready();
        case (t_rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom);
        endcase
    endtask

    task automatic run_txn();
        int rises0;
        int attempts;
        int act;
        int hs;
        int guard;
        int c;
        build_frame();
        load_buf();
        rises0   = req_rises;
        attempts = 0;
        start_send();
        check("busy_after_send", {31'b0, busy}, 32'd1);
        for (int a = 0; a <= int'(MAX_RETRY); a++) begin
            act = t_act[a];
            attempts++;
            wait_req();
            // Ignored disturbances while requesting: ack/nak, send, buffer writes.
            for (int d = 0; d < t_dly[a]; d++) begin
                if (t_noise) begin
                    hub_ack   = 1'($urandom);
                    hub_nak   = 1'($urandom);
                    send      = 1'($urandom);
                    load_en   = 1'($urandom);
                    load_addr = 4'($urandom);
                    load_data = 8'($urandom);
                end
                tick();
            end
            hub_ack = 1'b0;
            hub_nak = 1'b0;
            send    = 1'b0;
            load_en = 1'b0;
            hub_gnt = 1'b1;
            if (act == A_ACK) exp_out_q.push_back(2'b10);
            else if (a == int'(MAX_RETRY)) exp_out_q.push_back(2'b01);
            push_bytes((act == A_DROP) ? t_k[a] : m_flen);
            hs    = 0;
            guard = 0;
            forever begin
                tick();
                guard++;
                if (act == A_DROP && tx_valid && hs == t_k[a]) begin
                    hub_gnt  = 1'b0;
                    tx_ready = 1'b0;
                    break;
                end
                if (act != A_DROP && hs == m_flen) break;
                if (guard > 200) begin
                    check("frame_progress", 32'(hs), 32'(m_flen));
                    break;
                end
                set_ready();
                if (tx_valid && tx_ready) hs++;
            end
            tx_ready = 1'b0;
            hub_gnt  = 1'b0;
            if (act == A_TMO) begin
                c = 0;
                while (!(hub_req || fail) && c < 200) begin
                    tick();
                    c++;
                end
                check("timeout_cycles", 32'(c),
                      (a == int'(MAX_RETRY)) ? 32'(TIMEOUT) : 32'(TIMEOUT + 1));
            end else begin
                if (act == A_DROP) begin
                    tick();
                end else begin
                    for (int d = 0; d < t_rsp; d++) tick();
                    hub_ack = (act == A_ACK) || (act == A_BOTH);
                    hub_nak = (act == A_NAK) || (act == A_BOTH);
                    tick();
                    hub_ack = 1'b0;
                    hub_nak = 1'b0;
                end
                check("valid_after_attempt", {31'b0, tx_valid}, 32'd0);
                if (act != A_ACK && a < int'(MAX_RETRY)) begin
                    check("gap_req_low", {31'b0, hub_req}, 32'd0);
                    tick();
                    check("req_after_gap", {31'b0, hub_req}, 32'd1);
                end
            end
            if (act == A_ACK) break;
        end
        wait_idle();
        tick();
        check("outcomes_drained", 32'(exp_out_q.size()), 32'd0);
        check("bytes_drained", 32'(exp_byte_q.size()), 32'd0);
        check("attempt_count", 32'(req_rises - rises0), 32'(attempts));
    endtask

    task automatic set_simple(input logic [3:0] dst, input logic [3:0] len, input int mode);
        t_dst      = dst;
        t_len      = len;
        t_rdy_mode = mode;
        t_noise    = 1'b0;
        t_rsp      = 0;
        for (int i = 0; i < 4; i++) begin
            t_act[i] = A_ACK;
            t_k[i]   = 0;
            t_dly[i] = 2;
        end
    endtask

    task automatic reset_mid_data();
        set_simple(4'd9, 4'd4, 0);
        for (int i = 0; i < 16; i++) t_pay[i] = 8'($urandom);
        build_frame();
        load_buf();
        start_send();
        wait_req();
        hub_gnt = 1'b1;
        push_bytes(3);
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (exp_byte_q.size() == 0) break;
        end
        reset    = 1'b0;
        tx_ready = 1'b0;
        hub_gnt  = 1'b0;
        tick();
        check("rst_hub_req", {31'b0, hub_req}, 32'd0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_last", {31'b0, tx_last}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_fail", {31'b0, fail}, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        check("rst_stays_idle", {31'b0, hub_req}, 32'd0);
        check("rst_bytes_drained", 32'(exp_byte_q.size()), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset     = 1'b0;
        load_en   = 1'b0;
        load_addr = 4'h0;
        load_data = 8'h00;
        send      = 1'b0;
        send_dst  = 4'h0;
        send_len  = 4'h0;
        hub_gnt   = 1'b0;
        tx_ready  = 1'b0;
        hub_ack   = 1'b0;
        hub_nak   = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("reset_hub_req", {31'b0, hub_req}, 32'd0);
        check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("reset_tx_last", {31'b0, tx_last}, 32'd0);
        check("reset_tx_data", {24'b0, tx_data}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_fail", {31'b0, fail}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic frame, always ready.
        set_simple(4'd5, 4'd2, 0);
        t_pay[0] = 8'hA0;
        t_pay[1] = 8'h0F;
        run_txn();
        // Same frame with stalls.
        set_simple(4'd5, 4'd2, 1);
        run_txn();
        // Empty payload.
        set_simple(4'd2, 4'd0, 0);
        run_txn();
        // NAK twice then ACK.
        set_simple(4'd7, 4'd3, 2);
        for (int i = 0; i < 16; i++) t_pay[i] = 8'($urandom);
        t_act[0] = A_NAK;
        t_act[1] = A_NAK;
        run_txn();
        // Never answered: all attempts time out.
        set_simple(4'd1, 4'd1, 0);
        for (int i = 0; i < 4; i++) t_act[i] = A_TMO;
        run_txn();
        // Grant dropped mid-payload, then simultaneous ack/nak, then ACK.
        set_simple(4'd4, 4'd5, 2);
        t_act[0] = A_DROP;
        t_k[0]   = 3;
        t_act[1] = A_BOTH;
        run_txn();
        // Reset in the middle of a frame.
        reset_mid_data();

        // Randomized transactions with ignored noise while busy.
        for (int n = 0; n < 30; n++) begin
            t_dst      = 4'($urandom);
            t_len      = 4'($urandom);
            t_rdy_mode = int'($urandom_range(0, 2));
            t_noise    = 1'b1;
            t_rsp      = int'($urandom_range(0, 5));
            for (int i = 0; i < 16; i++) t_pay[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(0, 19));
                if (r < 10)      t_act[i] = A_ACK;
                else if (r < 14) t_act[i] = A_NAK;
                else if (r < 16) t_act[i] = A_BOTH;
                else if (r < 19) t_act[i] = A_DROP;
                else             t_act[i] = A_TMO;
                t_k[i]   = int'($urandom_range(0, int'(t_len) + 2));
                t_dly[i] = int'($urandom_range(0, 3));
            end
            run_txn();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
